// File: rtl/digi_logic_pkg.sv
// rtl/digi_logic_pkg.sv - shared constants and helpers for the multi-channel logic LUT
package digi_logic_pkg;

  // Table defaults reproduce the fixed equations, so both modes agree after reset.
  localparam logic [15:0] LUT1_DEFAULT = 16'hFF5E;
  localparam logic [15:0] LUT2_DEFAULT = 16'h5505;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_TABLE = 1'b1;

  function automatic logic [3:0] make_idx(input logic a, input logic b,
                                          input logic c, input logic d);
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/digi_logic_eval.sv
// rtl/digi_logic_eval.sv - combinational single-channel evaluator (fixed equations or tables)
module digi_logic_eval
  import digi_logic_pkg::*;
(
  input  logic [3:0]  idx_i,
  input  logic        mode_i,
  input  logic [15:0] t1_i,
  input  logic [15:0] t2_i,
  output logic        out1_o,
  output logic        out2_o
);

  logic a, b, c, d;

  always_comb begin
    a      = idx_i[3];
    b      = idx_i[2];
    c      = idx_i[1];
    d      = idx_i[0];
    out1_o = a | (c & ~b) | ((b & ~a) ^ d);
    out2_o = ~(d | (b & ~a));
    if (mode_i == MODE_TABLE) begin
      out1_o = t1_i[idx_i];
      out2_o = t2_i[idx_i];
    end else if (mode_i != MODE_FIXED) begin
      out1_o = 1'b0;
      out2_o = 1'b0;
    end
  end

endmodule

// File: rtl/digi_logic_lut.sv
// rtl/digi_logic_lut.sv - pipelined multi-channel logic evaluator with programmable tables
module digi_logic_lut
  import digi_logic_pkg::*;
#(
  parameter int CH     = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH-1:0]    a,
  input  logic [CH-1:0]    b,
  input  logic [CH-1:0]    c,
  input  logic [CH-1:0]    d,
  input  logic             mode,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [15:0]      cfg_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH-1:0]    out1,
  output logic [CH-1:0]    out2,
  output logic [CNT_W-1:0] eval_cnt
);

  logic [15:0]       t1_q, t2_q;
  logic [STAGES-1:0] vld_q;
  logic [CH-1:0]     o1_q [STAGES];
  logic [CH-1:0]     o2_q [STAGES];
  logic [CNT_W-1:0]  cnt_q;
  logic [CH-1:0]     ev1, ev2;
  logic              advance;

  assign out_valid = vld_q[STAGES-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign out1      = o1_q[STAGES-1];
  assign out2      = o2_q[STAGES-1];
  assign eval_cnt  = cnt_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    digi_logic_eval u_eval (
      .idx_i  (make_idx(a[i], b[i], c[i], d[i])),
      .mode_i (mode),
      .t1_i   (t1_q),
      .t2_i   (t2_q),
      .out1_o (ev1[i]),
      .out2_o (ev2[i])
    );
  end

  // Evaluation uses the tables as they stand before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      t1_q  <= LUT1_DEFAULT;
      t2_q  <= LUT2_DEFAULT;
      vld_q <= '0;
      cnt_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        o1_q[s] <= '0;
        o2_q[s] <= '0;
      end
    end else begin
      if (cfg_we) begin
        if (cfg_sel) t2_q <= cfg_data;
        else         t1_q <= cfg_data;
      end
      if (advance) begin
        vld_q[0] <= in_valid;
        o1_q[0]  <= ev1;
        o2_q[0]  <= ev2;
        for (int s = 1; s < STAGES; s++) begin
          vld_q[s] <= vld_q[s-1];
          o1_q[s]  <= o1_q[s-1];
          o2_q[s]  <= o2_q[s-1];
        end
      end
      if (out_valid && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_digi_logic_lut.sv
// tb/tb_digi_logic_lut.sv - scoreboard bench for digi_logic_lut against a truth-table model
module tb_digi_logic_lut;

  localparam int CH     = 4;
  localparam int STAGES = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_ready4;
  logic [CH-1:0] a, b, c, d;
  logic          mode, cfg_we, cfg_sel;
  logic [15:0]   cfg_data;
  logic          out_valid, out_ready, out_valid4;
  logic [CH-1:0] out1, out2, out1_4, out2_4;
  logic [15:0]   eval_cnt;
  logic [3:0]    eval_cnt4;

  always #5 clk = ~clk;

  digi_logic_lut #(.CH(CH), .STAGES(STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .mode(mode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .eval_cnt(eval_cnt)
  );

  digi_logic_lut #(.CH(CH), .STAGES(STAGES), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .c(c), .d(d), .mode(mode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out1(out1_4), .out2(out2_4), .eval_cnt(eval_cnt4)
  );

  typedef struct {
    logic [CH-1:0] o1;
    logic [CH-1:0] o2;
  } res_t;

  res_t        sb[$];
  logic [15:0] m_t1 = 16'hFF5E;
  logic [15:0] m_t2 = 16'h5505;
  int          exp_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          bp_active = 0;
  bit          rand_rdy = 0;
  int          bp_cyc = 0;
  bit          held_v = 0;
  logic [CH-1:0] held1, held2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each channel's index selects a truth-table bit; mode 0 uses the textbook equations.
  function automatic res_t model(input logic [CH-1:0] ia, input logic [CH-1:0] ib,
                                 input logic [CH-1:0] ic, input logic [CH-1:0] id,
                                 input logic im, input logic [15:0] t1, input logic [15:0] t2);
    res_t r;
    if (!im) begin
      r.o1 = ia | (ic & ~ib) | ((ib & ~ia) ^ id);
      r.o2 = ~(id | (ib & ~ia));
    end else begin
      for (int i = 0; i < CH; i++) begin
        int k;
        k = 8 * int'(ia[i]) + 4 * int'(ib[i]) + 2 * int'(ic[i]) + int'(id[i]);
        r.o1[i] = t1[k];
        r.o2[i] = t2[k];
      end
    end
    return r;
  endfunction

  // Stimulus side of the scoreboard: record expected result of every accepted beat.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      sb.delete();
      m_t1 = 16'hFF5E;
      m_t2 = 16'h5505;
    end else begin
      if (in_valid && in_ready) sb.push_back(model(a, b, c, d, mode, m_t1, m_t2));
      if (cfg_we) begin
        if (cfg_sel) m_t2 = cfg_data;
        else         m_t1 = cfg_data;
      end
    end
  end

  // Output monitor: handshakes, counter, stall stability.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      exp_cnt = 0;
      held_v  = 0;
    end else begin
      check("eval_cnt", 32'(eval_cnt), exp_cnt);
      check("eval_cnt_sat4", 32'(eval_cnt4), (exp_cnt > 15) ? 15 : exp_cnt);
      if (held_v && out_valid) begin
        check("stall_out1", 32'(out1), 32'(held1));
        check("stall_out2", 32'(out2), 32'(held2));
      end
      if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 0);
      else                         check("in_ready_free", 32'(in_ready), 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_output: got out1=%h out2=%h expected no beat", out1, out2);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("out1", 32'(out1), 32'(e.o1));
          check("out2", 32'(out2), 32'(e.o2));
        end
        exp_cnt++;
      end
      held_v = out_valid && !out_ready;
      held1  = out1;
      held2  = out2;
    end
  end

  always @(negedge clk) begin
    if (bp_active) begin
      bp_cyc++;
      out_ready = !(bp_cyc >= 3 && bp_cyc <= 7);
    end else if (rand_rdy) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic send(input logic [CH-1:0] ia, input logic [CH-1:0] ib,
                      input logic [CH-1:0] ic, input logic [CH-1:0] id, input logic im,
                      input logic we = 1'b0, input logic sel = 1'b0, input logic [15:0] dat = 16'h0);
    int guard;
    guard = 0;
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; mode = im;
    in_valid = 1'b1; cfg_we = we; cfg_sel = sel; cfg_data = dat;
    #4;
    while (!in_ready) begin
      guard++;
      if (guard > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        break;
      end
      @(negedge clk);
      #4;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we   = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 300) begin
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      #4;
      g++;
    end
    if (g >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    logic [CH-1:0] va, vb, vc, vd;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0; d = '0; mode = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out1", 32'(out1), 0);
    check("reset_out2", 32'(out2), 0);
    check("reset_eval_cnt", 32'(eval_cnt), 0);
    check("reset_in_ready", 32'(in_ready), 1);

    // Fixed mode single beat plus latency
    send(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      lat++;
    end while (!out_valid && lat < 20);
    check("latency_edges", lat, STAGES);
    check("fixed_out1", 32'(out1), 32'h1);
    check("fixed_out2", 32'(out2), 32'hF);
    drain();

    // Equivalence sweep: beat j covers idx 4*(j%4)+i, mode j/4
    do_reset();
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < CH; i++) begin
        int k;
        k = 4 * (j % 4) + i;
        va[i] = k[3]; vb[i] = k[2]; vc[i] = k[1]; vd[i] = k[0];
      end
      send(va, vb, vc, vd, (j >= 4));
    end
    drain();
    check("sweep_eval_cnt", 32'(eval_cnt), 8);

    // Config race at idx 15 then idx 14
    send(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 16'h8000);
    send(4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
    idle(1);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 16'hFF5E;
    send(4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 16'h8000);
    send(4'hF, 4'hF, 4'hF, 4'h0, 1'b1);
    drain();

    // Backpressure window
    bp_cyc = 0;
    bp_active = 1;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      send(kk, ~kk, kk + 4'd3, kk ^ 4'd5, kk[0]);
    end
    drain();
    bp_active = 0;

    // Reset with beats in flight and T1 reprogrammed
    send(4'h3, 4'h5, 4'h9, 4'hA, 1'b1, 1'b1, 1'b0, 16'h0000);
    send(4'hC, 4'h6, 4'h1, 4'h7, 1'b1);
    do_reset();
    #4;
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_eval_cnt", 32'(eval_cnt), 0);
    check("rst_mid_in_ready", 32'(in_ready), 1);
    send(4'h0, 4'hF, 4'h0, 4'hF, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      lat++;
    end while (!out_valid && lat < 20);
    check("rst_idx5_out1", 32'(out1), 0);
    check("rst_idx5_out2", 32'(out2), 0);
    drain();

    // Saturation of the 4-bit counter
    do_reset();
    for (int k = 0; k < 20; k++) begin
      send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    drain();
    check("sat_cnt16", 32'(eval_cnt), 20);
    check("sat_cnt4", 32'(eval_cnt4), 15);

    // Randomized traffic with random backpressure and table writes
    rand_rdy = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0), 1'($urandom), 16'($urandom));
    end
    drain();
    rand_rdy = 0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digi_logic_lut.md
# digi_logic_lut

Pipelined, multi-channel successor to the fixed four-input two-output logic evaluator. Each accepted beat carries CH independent channels of inputs a/b/c/d. Every channel produces out1/out2 through either the legacy fixed equations or two run-time programmable 16-entry truth tables. Sits between a valid/ready producer and consumer, with elastic backpressure and a saturating beat counter.

## Interface
- CH, 4: channel count; bit i of every data port belongs to channel i.
- STAGES, 2: register stages from input acceptance to output; legal range 1..4.
- CNT_W, 16: width of the evaluation counter.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a, b, c, d  in  CH each  per-channel logic inputs.
- mode  in  1  sampled with the beat: 0 = fixed equations, 1 = programmable tables.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  1  table select: 0 = out1 table, 1 = out2 table.
- cfg_data  in  16  new table contents; bit k is the output for index k.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts the beat.
- out1, out2  out  CH each  per-channel results.
- eval_cnt  out  CNT_W  number of completed output handshakes, saturating.

## Operation
- Index per channel: idx = {a[i], b[i], c[i], d[i]}, with a as the MSB, giving 0..15.
- Mode 0 computes the fixed equations:
  - out1 = a | (c & ~b) | ((b & ~a) ^ d)
  - out2 = ~(d | (b & ~a))
- Mode 1 computes out1 = T1[idx] and out2 = T2[idx].
- Table reset values are T1 = 16'hFF5E and T2 = 16'h5505. These equal the mode-0 functions, so mode 1 after reset matches mode 0 bit for bit.
- Table write: on a cycle with cfg_we = 1, the table chosen by cfg_sel takes cfg_data at the clock edge. There is no partial write.
- Mode and table contents are sampled at input acceptance (in_valid & in_ready):
  - A beat accepted in the same cycle as a cfg_we uses the old table.
  - The first beat accepted after that edge uses the new table.
  - A table write never alters a beat that is already in flight.
- Pipeline: STAGES registers, each holding a valid bit and result data, with a global advance.
  - advance = ~out_valid | out_ready.
  - When advance is high, every stage shifts by one and stage 0 loads the evaluated beat, with valid = in_valid.
  - in_ready = advance. This is combinational from out_valid and out_ready only; there is no path from in_valid.
  - Bubbles travel through the pipeline and are not collapsed.
- Output data registers change only on advance and hold their value while stalled. Data presented with out_valid = 0 is don't-care, but it is deterministic.
- eval_cnt increments on each out_valid & out_ready and saturates at 2^CNT_W − 1. It never wraps.

## Timing
- Reset values: out_valid = 0, out1 = 0, out2 = 0, eval_cnt = 0, all stage valids = 0, T1/T2 = defaults.
- in_ready is 1 in the first cycle after reset.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n + STAGES − 1, i.e. registered output after STAGES edges, assuming no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0:
  - in_ready = 0 and nothing moves.
  - out1/out2 stay stable.
  - No beat is lost or duplicated, and order is preserved.
- Holding in_valid high while in_ready = 0 is legal. The beat is taken on the first cycle with in_ready = 1.
- Reset mid-operation: all in-flight beats are discarded, tables return to defaults, and the counter clears. No output handshake completes in the reset cycle.
- cfg_we during a stall is still applied.
- A cfg_we in the reset cycle is ignored; reset wins.

## Structure
- Package digi_logic_pkg holds:
  - the default constants LUT1_DEFAULT = 16'hFF5E and LUT2_DEFAULT = 16'h5505;
  - the index-forming function;
  - the mode encoding constants.
- Sub-module digi_logic_eval: a purely combinational single-channel evaluator that takes idx, mode, T1 and T2 and returns out1/out2. The top instantiates it CH times in a generate loop.
- The top owns the tables, the pipeline registers, the handshake and the counter.

## Test plan
- Fixed mode (CH = 4, STAGES = 2): after reset, send mode = 0, a = 4'b0001, b = c = d = 0.
  - Expect out1 = 4'b0001 and out2 = 4'b1111, with out_valid rising exactly 2 edges after acceptance.
- Equivalence sweep: drive all 16 indices in both modes (channel i carries idx = 4·beat + i).
  - Every out1/out2 bit matches the fixed equations.
  - eval_cnt = 8 after the 8 beats.
- Config race: write cfg_sel = 0, cfg_data = 16'h8000 in the same cycle a beat with all inputs = 1 is accepted, then send an identical beat.
  - First result: out1 = 4'b1111 (old table).
  - Second result: out1 = 4'b1111 (AND4, idx 15).
  - Repeat the pair with inputs at idx 14: results are 1111, then 0000.
- Backpressure: stream 10 distinct beats with out_ready low for cycles 3–7.
  - in_ready drops within the same cycle, outputs hold during the stall, and all 10 results arrive in order with none missing.
- Reset mid-stream: assert rst with two beats in flight and T1 reprogrammed.
  - Next cycle: out_valid = 0, eval_cnt = 0, in_ready = 1.
  - A mode-1 idx-5 beat yields out1 = 0 and out2 = 0 (defaults restored).
- Saturation (CNT_W = 4): complete 20 handshakes; eval_cnt reads 15, not 4.
